// File: rtl/wallace_pkg.sv
// ---------------------------------------------------------------------------
// wallace_pkg
// Shared constants and types for the Booth multiplier reduction stage.
//   PP_W     : width of every partial-product row
//   NUM_PP   : number of radix-4 Booth partial products for an 8-bit operand
//   PP_SHIFT : bit distance between consecutive partial-product weights
//   LATENCY  : register stages between input acceptance and P
// align_pp() places partial product idx at its arithmetic weight, dropping
// anything pushed above the top bit (the product is taken modulo 2^PP_W).
// ---------------------------------------------------------------------------
package wallace_pkg;

    localparam int PP_W     = 16;
    localparam int NUM_PP   = 4;
    localparam int PP_SHIFT = 2;
    localparam int LATENCY  = 3;

    typedef logic [PP_W-1:0] pp_t;

    function automatic pp_t align_pp(input pp_t pp, input int idx);
        return pp_t'(pp << (PP_SHIFT * idx));
    endfunction

endpackage

// File: rtl/csa_row.sv
// ---------------------------------------------------------------------------
// csa_row
// Parametrised-width 3:2 carry-save row. Each bit position is an independent
// full adder: sum is the XOR of the three inputs, carry is their majority.
// The carry output is NOT pre-shifted; the caller applies the x2 weight.
//   W        : row width
//   a_i/b_i/c_i : the three rows to compress
//   sum_o    : per-bit sum, weight 2^i
//   carry_o  : per-bit carry, weight 2^(i+1)
// ---------------------------------------------------------------------------
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ c_i[gi];
        assign carry_o[gi] = (a_i[gi] & b_i[gi]) | (a_i[gi] & c_i[gi]) | (b_i[gi] & c_i[gi]);
    end

endmodule

// File: rtl/wallace_reduce_pipe.sv
// ---------------------------------------------------------------------------
// wallace_reduce_pipe
// Reduction and final-add stage of the 8-bit radix-4 Booth multiplier.
// Three register stages:
//   S1 align    : rows W, X<<2, Y<<4, Z<<6
//   S2 compress : two CSA levels -> sum row and pre-shifted carry row
//   S3 CPA      : P = sum + carry (mod 2^16)
// Each stage advances when it is empty or the next stage advances, so bubbles
// collapse and the pipeline holds up to three results under backpressure.
// Data presented in cycle c (and accepted) is on P with out_valid in cycle c+3.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready does not depend on in_valid)
//   W, X, Y, Z          : sign-extended unshifted partial products PP0..PP3
//   in_tag              : sideband tag (only with WALLACE_TAG_EN)
//   out_valid/out_ready : output handshake
//   P                   : 16-bit two's-complement product
//   out_tag             : tag aligned with P (only with WALLACE_TAG_EN)
//
// Optional feature macro: WALLACE_TAG_EN (carries in_tag alongside the data).
// ---------------------------------------------------------------------------
module wallace_reduce_pipe
    import wallace_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      W,
    input  logic [15:0]      X,
    input  logic [15:0]      Y,
    input  logic [15:0]      Z,
`ifdef WALLACE_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      P
);

    // ---------------- flow control ----------------
    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;

    // Chain runs from the output backwards; in_valid never enters it.
    assign adv3     = !v3_q || out_ready;
    assign adv2     = !v2_q || adv3;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
        end
    end

    // ---------------- S1: align ----------------
    pp_t pp_in [NUM_PP];
    pp_t row_d [NUM_PP];
    pp_t row_q [NUM_PP];

    assign pp_in[0] = W;
    assign pp_in[1] = X;
    assign pp_in[2] = Y;
    assign pp_in[3] = Z;

    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_align
        assign row_d[gi] = align_pp(pp_in[gi], gi);

        always_ff @(posedge clk) begin
            if (adv1) row_q[gi] <= row_d[gi];
        end
    end

    // ---------------- S2: compress ----------------
    pp_t s_a, c_a, c_a_sh, s_b, c_b;
    pp_t sb_q, cb_q;

    csa_row #(.W(PP_W)) u_csa_l1 (
        .a_i     (row_q[0]),
        .b_i     (row_q[1]),
        .c_i     (row_q[2]),
        .sum_o   (s_a),
        .carry_o (c_a)
    );

    // Carry bit 15 falls off here: it would only affect bit 16 and above.
    assign c_a_sh = {c_a[PP_W-2:0], 1'b0};

    csa_row #(.W(PP_W)) u_csa_l2 (
        .a_i     (s_a),
        .b_i     (c_a_sh),
        .c_i     (row_q[3]),
        .sum_o   (s_b),
        .carry_o (c_b)
    );

    always_ff @(posedge clk) begin
        if (adv2) begin
            sb_q <= s_b;
            cb_q <= {c_b[PP_W-2:0], 1'b0};
        end
    end

    // ---------------- S3: carry-propagate add ----------------
    pp_t p_d, p_q;

    assign p_d = sb_q + cb_q;

    // P is reset so the output reads zero after reset, not stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else if (adv3) begin
            p_q <= p_d;
        end
    end

    assign P         = p_q;
    assign out_valid = v3_q;

`ifdef WALLACE_TAG_EN
    // ---------------- tag sideband, same advance enables as the data ----------------
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    always_ff @(posedge clk) begin
        if (adv1) tag1_q <= in_tag;
        if (adv2) tag2_q <= tag1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag3_q <= '0;
        end else if (adv3) begin
            tag3_q <= tag2_q;
        end
    end

    assign out_tag = tag3_q;
`endif

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_reduce_pipe
// Directed bench for wallace_reduce_pipe. Expected products are hand-computed
// constants in the vector tables. Inputs change and outputs are sampled 1-2ns
// after the rising edge. Define WALLACE_TAG_EN to also check out_tag ordering.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wallace_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] W, X, Y, Z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic [3:0]  in_tag;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    wallace_reduce_pipe #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
`ifdef WALLACE_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

`ifndef WALLACE_TAG_EN
    assign out_tag = 4'h0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        else
            n_pass++;
    endtask

    // vector tables: rows, expected product, tag
    logic [15:0] vw [8], vx [8], vy [8], vz [8], ve [8];
    logic [3:0]  vt [8];

    task automatic set_vec(input int i, input logic [15:0] w, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z,
                           input logic [15:0] e, input logic [3:0] t);
        vw[i] = w; vx[i] = x; vy[i] = y; vz[i] = z; ve[i] = e; vt[i] = t;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready high, mode 1: out_ready low for first 6 cycles,
    // mode 2: random out_ready
    task automatic run_stream(input int n, input int mode);
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        int first = 0;
        bit acc_in, acc_out;
        while (recv < n && cyc < 300) begin
            in_valid = (sent < n);
            if (sent < n) begin
                W = vw[sent]; X = vx[sent]; Y = vy[sent]; Z = vz[sent]; in_tag = vt[sent];
            end else begin
                W = 16'h0; X = 16'h0; Y = 16'h0; Z = 16'h0; in_tag = 4'h0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc >= 6);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (mode == 1 && cyc < 6) begin
                if (cyc >= 3) check("full_in_ready", {31'b0, in_ready}, 32'd0);
                if (out_valid) check("stall_hold_P", {16'b0, P}, {16'b0, ve[0]});
            end
            if (mode == 1 && cyc == 6) check("accepts_during_stall", sent, 32'd3);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                $display("out #%0d P=%h exp=%h tag=%h", recv, P, ve[recv], out_tag);
                check("P", {16'b0, P}, {16'b0, ve[recv]});
`ifdef WALLACE_TAG_EN
                check("out_tag", {28'b0, out_tag}, {28'b0, vt[recv]});
`endif
                if (mode == 0) begin
                    if (recv == 0) begin
                        first = cyc;
                        check("stream_latency", cyc, 32'd3);
                    end else begin
                        check("b2b_cycle", cyc, first + recv);
                    end
                end
                recv++;
            end
            @(posedge clk);
            if (acc_in) sent++;
            #1;
            cyc++;
        end
        check("stream_done", recv, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        W = 16'h0; X = 16'h0; Y = 16'h0; Z = 16'h0; in_tag = 4'h0;

        // ---- reset state ----
        tick; tick;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_P", {16'b0, P}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_tag", {28'b0, out_tag}, 32'd0);
        rst = 1'b0;
        tick;

        // ---- single op: -3 x 5 -> -15, 3 cycles of latency ----
        W = 16'hFFFD; X = 16'hFFFD; Y = 16'h0; Z = 16'h0; in_valid = 1'b1;
        #1;
        check("single_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0; W = 16'h0; X = 16'h0;
        check("single_ov_c1", {31'b0, out_valid}, 32'd0);
        tick;
        check("single_ov_c2", {31'b0, out_valid}, 32'd0);
        tick;
        check("single_ov_c3", {31'b0, out_valid}, 32'd1);
        check("single_P", {16'b0, P}, 32'h0000FFF1);
        $display("single op P=%h", P);
        tick;
        check("single_ov_c4", {31'b0, out_valid}, 32'd0);
        tick;

        // ---- back-to-back stream: 127x-128, -128x-128, 0x55 ----
        set_vec(0, 16'h0000, 16'h0000, 16'h0000, 16'hFF02, 16'hC080, 4'h1);
        set_vec(1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h4000, 4'h2);
        set_vec(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h3);
        run_stream(3, 0);

        // ---- all-ones rows: -1 -4 -16 -64 = -85 ----
        set_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFAB, 4'h5);
        run_stream(1, 0);

        // ---- backpressure: 6 stall cycles while feeding 5 inputs ----
        set_vec(0, 16'hFFFD, 16'hFFFD, 16'h0000, 16'h0000, 16'hFFF1, 4'h1);
        set_vec(1, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0055, 4'h2);
        set_vec(2, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 4'h3);
        set_vec(3, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0040, 4'h4);
        set_vec(4, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0050, 4'h5);
        run_stream(5, 1);

        // ---- reset with two results in flight ----
        out_ready = 1'b0;
        W = 16'h0001; X = 16'h0001; Y = 16'h0001; Z = 16'h0001; in_valid = 1'b1;
        tick; tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_P", {16'b0, P}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end

        // ---- tags 1..4 with random output stalls ----
        set_vec(0, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0055, 4'h1);
        set_vec(1, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 4'h2);
        set_vec(2, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0040, 4'h3);
        set_vec(3, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0050, 4'h4);
        run_stream(4, 2);

        tick; tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
